// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters, with lock and per-requester ov context
module alu_share_arbiter #(
  parameter int W = 8,
  parameter int OPW = 5,
  parameter int MAX_OP = 19
) (
  input  logic           CLK,
  input  logic           reset_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req0_lock,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic           req1_lock,
  output logic [OPW-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_ov_in,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_ov_out,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_ov,
  output logic           rsp_err
);
  localparam logic [OPW-1:0] kNop = OPW'(9);
  localparam logic [OPW-1:0] kMaxOp = OPW'(MAX_OP);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, stateNext;
  logic [OPW-1:0] issOp, selOp;
  logic [W-1:0] issA, issB, rspData;
  logic issId, issErr, rspOv, lastGrant, lockValid, lockOwner;
  logic elig0, elig1, win1, grant;
  logic [1:0] ov;
  always_comb begin
    elig0 = req0_valid && (!lockValid || !lockOwner);
    elig1 = req1_valid && (!lockValid || lockOwner);
    win1 = elig1 && (!elig0 || !lastGrant);
    grant = (state == IDLE) && (elig0 || elig1);
    req0_ready = grant && !win1;
    req1_ready = grant && win1;
    selOp = win1 ? req1_op : req0_op;
    alu_op = (state == EXEC && !issErr) ? issOp : kNop;
    alu_a = (state == EXEC) ? issA : '0;
    alu_b = (state == EXEC) ? issB : '0;
    alu_ov_in = (state == EXEC) && ov[issId];
    stateNext = (state == IDLE) ? (grant ? EXEC : IDLE) :
                (state == EXEC) ? RESP : (rsp_ready ? IDLE : RESP);
  end
  assign rsp_valid = (state == RESP);
  assign rsp_id = rsp_valid && issId;
  assign rsp_data = rsp_valid ? rspData : '0;
  assign rsp_ov = rsp_valid && rspOv;
  assign rsp_err = rsp_valid && issErr;
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      issOp <= kNop;
      issA <= '0;
      issB <= '0;
      issId <= 1'b0;
      issErr <= 1'b0;
      rspData <= '0;
      rspOv <= 1'b0;
      ov <= 2'b00;
      lastGrant <= 1'b1;
      lockValid <= 1'b0;
      lockOwner <= 1'b0;
    end else begin
      state <= stateNext;
      if (grant) begin
        issOp <= selOp;
        issA <= win1 ? req1_a : req0_a;
        issB <= win1 ? req1_b : req0_b;
        issId <= win1;
        issErr <= selOp > kMaxOp;
        lastGrant <= win1;
        lockValid <= win1 ? req1_lock : req0_lock;
        lockOwner <= win1;
      end
      // an illegal op leaves its requester's ov context untouched
      if (state == EXEC) begin
        rspData <= issErr ? '0 : alu_result;
        rspOv <= issErr ? ov[issId] : alu_ov_out;
        if (!issErr) ov[issId] <= alu_ov_out;
      end
    end
  end
endmodule
